// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready producers.
// Optional per-requester beat counters are built when FIFO_ARB_STATS_EN is defined.
`ifndef DEF_FIFO_WIDTH
`define DEF_FIFO_WIDTH 8
`endif

module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = `DEF_FIFO_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wr_en,
  output logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [NUM_REQ*16-1:0]         stat_beats
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_grant_id;
  logic [ID_W-1:0] w_grant_nxt;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] w_ptr_nxt;
  logic [7:0]      r_beat_cnt;
  logic [7:0]      w_cnt_nxt;

  logic            w_any;
  logic [ID_W-1:0] w_pick_id;
  logic            w_gvalid;
  logic            w_accept;
  logic [ID_W-1:0] w_grant_inc;

  // Walk offsets from high to low so the lowest offset from r_rr_ptr wins.
  always_comb begin : pick_c
    int idx;
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path through the block can leave it holding (a latch).
    w_any     = 1'b0;
    w_pick_id = '0;
    idx       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[ID_W'(idx)]) begin
        w_any     = 1'b1;
        w_pick_id = ID_W'(idx);
      end
    end
  end

  assign w_gvalid    = req_valid[r_grant_id];
  assign w_grant_inc = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

  always_comb begin : fsm_c
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    w_ptr_nxt   = r_rr_ptr;
    w_cnt_nxt   = r_beat_cnt;
    w_accept    = 1'b0;
    req_ready   = '0;
    wr_en       = 1'b0;
    data_in     = '0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_any) begin
          w_state_nxt = S_GRANT;
          w_grant_nxt = w_pick_id;
        end
      end
      S_GRANT: begin
        req_ready[r_grant_id] = ~full;
        w_accept              = w_gvalid & ~full;
        wr_en                 = w_accept;
        if (w_accept) begin
          data_in   = req_data[int'(r_grant_id) * FIFO_WIDTH +: FIFO_WIDTH];
          w_cnt_nxt = r_beat_cnt + 8'd1;
        end
        // A full stall with valid held keeps the grant; a producer gap or a
        // completed burst hands the port to the next requester.
        if (!w_gvalid || (w_accept && r_beat_cnt == 8'(BURST_LEN - 1))) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = w_grant_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state    <= S_IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant_id <= w_grant_nxt;
      r_rr_ptr   <= w_ptr_nxt;
      r_beat_cnt <= w_cnt_nxt;
    end
  end

  assign busy     = (r_state == S_GRANT);
  assign grant_id = r_grant_id;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] r_stat [NUM_REQ];

  // NOTE: this counter array is visible on a port, so unlike a data memory
  // it must be cleared by reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NUM_REQ; i++) r_stat[i] <= '0;
    end else if (w_accept && r_stat[r_grant_id] != 16'hFFFF) begin
      r_stat[r_grant_id] <= r_stat[r_grant_id] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_beats[g*16 +: 16] = r_stat[g];
  end
`else
  assign stat_beats = '0;
`endif

endmodule
